mem_wb_bridge: RTL and testbench
================================

Name: mem_wb_bridge

Overview:
- Registered, handshaked successor to the combinational CPU data-port router.
- Accepts one load/store at a time from the core and decodes the address into the local data memory region or the Wishbone FCB window.
- Wishbone path: drives a full cycle with ack/error/timeout handling, byte-lane select generation and load sign/zero extension.
- Reports misaligned and illegal accesses as errors, so the core can trap instead of receiving silent garbage.

Parameters:
- WB_BASE, 32'hFFFFFFE0, base address of the Wishbone window; must be aligned to 2**WB_SPAN_LOG2.
- WB_SPAN_LOG2, 5, log2 of the window size in bytes. Window is [WB_BASE, WB_BASE + 2**WB_SPAN_LOG2 - 1].
- WB_ADDR_W, 3, width of the Wishbone word address; equals WB_SPAN_LOG2 - 2.
- TIMEOUT, 15, number of WB_WAIT cycles without ack/error before the access is aborted. Range 1..255.

Ports:
- clk, in, 1, system clock.
- reset, in, 1, synchronous active-low reset.
- req_valid, in, 1, core request present.
- req_ready, out, 1, bridge can accept a request (high only in IDLE).
- req_write, in, 1, 1 = store, 0 = load.
- req_func3, in, 3, RISC-V funct3: 0 = B, 1 = H, 2 = W, 4 = BU, 5 = HU.
- req_addr, in, 32, byte address.
- req_wdata, in, 32, store data, right-aligned.
- rsp_valid, out, 1, one-cycle response pulse.
- rsp_rdata, out, 32, load result; extended on the WB path, pass-through on the memory path.
- rsp_err, out, 1, qualified by rsp_valid; high for misaligned access, illegal func3, wb_error or timeout.
- mem_addr, out, 32, memory byte address.
- mem_write, out, 1, memory write strobe.
- mem_data_in, out, 32, memory write data, unshifted.
- mem_control, out, 3, func3 forwarded to memory.
- mem_data_out, in, 32, memory read data, valid one cycle after the access.
- wb_address, out, WB_ADDR_W, Wishbone word address.
- wb_data_in, out, 32, Wishbone write data, lane-shifted.
- wb_data_out, in, 32, Wishbone read data.
- wb_we, out, 1, Wishbone write enable.
- wb_bus_cycle, out, 1, Wishbone CYC.
- wb_stb, out, 1, Wishbone STB.
- wb_select, out, 4, Wishbone byte lane selects.
- wb_ack, in, 1, Wishbone acknowledge.
- wb_error, in, 1, Wishbone error.

Behaviour:
- Reset (reset = 0 at a clk edge), including mid-transaction:
  - FSM goes to IDLE; in-flight access is dropped and no rsp_valid is issued for it.
  - req_ready = 1.
  - All other outputs = 0: rsp_*, mem_write, wb_bus_cycle, wb_stb, wb_we, wb_select, wb_address, wb_data_in, timeout counter.
- States: IDLE, MEM_WAIT, WB_WAIT, RESP.
- Accept: a request is accepted when req_valid & req_ready at a clk edge. The request is latched.
- Checks at accept:
  - Illegal: func3 is 3, 6 or 7.
  - Misaligned: H/HU with addr[0] = 1, or W with addr[1:0] != 0.
  - Either case -> RESP with rsp_err = 1, rsp_rdata = 0. No memory or WB activity.
- Memory path:
  - Region is any address outside the WB window.
  - mem_addr, mem_data_in and mem_control are driven from the latched request.
  - mem_write is high for exactly the one MEM_WAIT cycle, and only for stores.
  - Next edge -> RESP with rsp_rdata = mem_data_out, rsp_err = 0.
- WB path, entering WB_WAIT (registered outputs):
  - wb_bus_cycle = wb_stb = 1.
  - wb_address = addr[WB_SPAN_LOG2-1:2]; wb_we = req_write.
  - wb_data_in = wdata << (8 * addr[1:0]).
  - wb_select: B -> 0001 << addr[1:0]; H -> 0011 << addr[1:0]; W -> 1111.
- WB_WAIT exit conditions:
  - wb_ack -> capture wb_data_out, drop CYC/STB at the same edge, go to RESP.
  - wb_error -> drop CYC/STB, go to RESP with err = 1. If ack and error arrive together, error wins.
  - Counter reaches TIMEOUT -> abort, err = 1 (see Optional Feature).
- Load extension (WB path):
  - Shift captured data right by 8 * addr[1:0].
  - B/H: sign-extend bit 7 / bit 15. BU/HU: zero-extend. W: unchanged.
  - Stores return rsp_rdata = 0.
- RESP:
  - rsp_valid = 1 for exactly one cycle, then IDLE.
  - req_ready returns high the cycle after RESP.
- Latency (accept edge to rsp_valid):
  - Error: 1 cycle.
  - Memory: 2 cycles.
  - WB: (ack edge - accept edge) + 1 cycle.
- A request arriving while not IDLE is ignored; the core must hold it until accepted.
- Window boundaries are inclusive: WB_BASE and WB_BASE + 2**WB_SPAN_LOG2 - 1 are WB accesses; WB_BASE - 1 is a memory access.

Optional Feature:
- Macro: MEM_WB_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to WB_WAIT and increments each WB_WAIT cycle.
  - When it equals TIMEOUT with no ack/error: CYC/STB drop and RESP is issued with err = 1.
- Undefined:
  - No counter is present; WB_WAIT holds indefinitely until ack or error.
  - The TIMEOUT parameter is unused.

Test Plan:
- Hold reset = 0 for 2 edges while in WB_WAIT -> wb_bus_cycle = 0, rsp_valid never pulses, req_ready = 1 on the following cycle.
- SW 0xDEADBEEF to 0x00000100 -> mem_write high for 1 cycle with mem_addr = 0x100, mem_control = 2; rsp_valid 2 cycles after accept, err = 0.
- LB from 0xFFFFFFE5, slave acks 2 cycles later with 0x00008000 -> wb_address = 1, wb_select = 0010, rsp_rdata = 0xFFFFFF80. Same access as LBU -> rsp_rdata = 0x00000080.
- SH 0x00001234 to 0xFFFFFFE2 -> wb_data_in = 0x12340000, wb_select = 1100, wb_we = 1; on ack, rsp_err = 0.
- LW from 0x00000102 -> no mem_write and no CYC; rsp_valid with err = 1 one cycle after accept. Also func3 = 3 -> err = 1.
- With the macro defined and TIMEOUT = 15, WB read never acked -> CYC held 15 cycles, then dropped and rsp_err = 1. With the macro undefined, CYC is still high after 100 cycles; a later ack then completes the access normally.

Source files
------------

// File: rtl/mem_wb_bridge.sv
// mem_wb_bridge: registered load/store bridge from the core data port to the
// local data memory or the Wishbone FCB window.
// Build option: define MEM_WB_BRIDGE_TIMEOUT_EN to abort Wishbone cycles that
// are neither acked nor errored within TIMEOUT wait cycles.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// S_IDLE    | ready for a request; checks/decodes it on accept
// S_MEM_WAIT| single memory access cycle (mem_write pulses here for stores)
// S_WB_WAIT | Wishbone cycle open, waiting for ack / error / timeout
// S_RESP    | rsp_valid pulse, back to IDLE on the next edge
module mem_wb_bridge #(
  parameter logic [31:0] WB_BASE      = 32'hFFFFFFE0,
  parameter int          WB_SPAN_LOG2 = 5,
  parameter int          WB_ADDR_W    = 3,
  parameter int          TIMEOUT      = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_write,
  input  logic [2:0]           req_func3,
  input  logic [31:0]          req_addr,
  input  logic [31:0]          req_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [31:0]          mem_addr,
  output logic                 mem_write,
  output logic [31:0]          mem_data_in,
  output logic [2:0]           mem_control,
  input  logic [31:0]          mem_data_out,
  output logic [WB_ADDR_W-1:0] wb_address,
  output logic [31:0]          wb_data_in,
  input  logic [31:0]          wb_data_out,
  output logic                 wb_we,
  output logic                 wb_bus_cycle,
  output logic                 wb_stb,
  output logic [3:0]           wb_select,
  input  logic                 wb_ack,
  input  logic                 wb_error
);

  // Elaboration-time parameter sanity checks.
  if (WB_ADDR_W != WB_SPAN_LOG2 - 2) begin : g_bad_addr_w
    $error("mem_wb_bridge: WB_ADDR_W must equal WB_SPAN_LOG2 - 2");
  end
  if (WB_BASE[WB_SPAN_LOG2-1:0] != '0) begin : g_bad_base
    $error("mem_wb_bridge: WB_BASE must be aligned to the window size");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("mem_wb_bridge: TIMEOUT must be in 1..255");
  end

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_MEM_WAIT = 2'd1,
    S_WB_WAIT  = 2'd2,
    S_RESP     = 2'd3
  } state_t;

  state_t      state;
  logic        r_write;
  logic [2:0]  r_func3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic        rsp_from_mem;
  logic [31:0] rsp_rdata_q;

  logic        acc_illegal;
  logic        acc_misaligned;
  logic        acc_in_wb;
  logic [3:0]  acc_select;
  logic [31:0] wb_shifted;
  logic [31:0] wb_load;
  logic        wb_timeout;

  // Memory side is driven straight from the latched request.
  assign mem_addr    = r_addr;
  assign mem_data_in = r_wdata;
  assign mem_control = r_func3;

  // Memory reads pass through during RESP so a synchronous RAM has its data in time.
  assign rsp_rdata = rsp_from_mem ? mem_data_out : rsp_rdata_q;

  // Decode and check the incoming request (used only on the accept edge).
  always_comb begin
    acc_illegal    = (req_func3 == 3'd3) || (req_func3[2:1] == 2'b11);
    acc_misaligned = 1'b0;
    acc_select     = 4'b1111;
    case (req_func3[1:0])
      2'd0: acc_select = 4'b0001 << req_addr[1:0];
      2'd1: begin
        acc_select     = 4'b0011 << req_addr[1:0];
        acc_misaligned = req_addr[0];
      end
      2'd2: acc_misaligned = |req_addr[1:0];
      default: ;
    endcase
    acc_in_wb = (req_addr[31:WB_SPAN_LOG2] == WB_BASE[31:WB_SPAN_LOG2]);
  end

  // Lane-align and extend Wishbone read data using the latched request.
  always_comb begin
    wb_shifted = wb_data_out >> {r_addr[1:0], 3'b000};
    case (r_func3)
      3'd0:    wb_load = {{24{wb_shifted[7]}}, wb_shifted[7:0]};
      3'd1:    wb_load = {{16{wb_shifted[15]}}, wb_shifted[15:0]};
      3'd4:    wb_load = {24'd0, wb_shifted[7:0]};
      3'd5:    wb_load = {16'd0, wb_shifted[15:0]};
      default: wb_load = wb_shifted;
    endcase
    if (r_write) wb_load = '0;
  end

`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  logic [7:0] wb_cnt;

  assign wb_timeout = ((wb_cnt + 8'd1) == TIMEOUT_CNT);

  // Count Wishbone wait cycles; held at zero outside WB_WAIT so entry starts clean.
  always_ff @(posedge clk) begin
    if (!reset)                   wb_cnt <= '0;
    else if (state == S_WB_WAIT)  wb_cnt <= wb_cnt + 8'd1;
    else                          wb_cnt <= '0;
  end
`else
  assign wb_timeout = 1'b0;
`endif

  // Main sequencer with registered handshake, memory and Wishbone outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      req_ready    <= 1'b1;
      rsp_valid    <= 1'b0;
      rsp_err      <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_from_mem <= 1'b0;
      mem_write    <= 1'b0;
      wb_bus_cycle <= 1'b0;
      wb_stb       <= 1'b0;
      wb_we        <= 1'b0;
      wb_select    <= '0;
      wb_address   <= '0;
      wb_data_in   <= '0;
      r_write      <= 1'b0;
      r_func3      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
    end else begin
      rsp_valid <= 1'b0;
      mem_write <= 1'b0;
      case (state)
        S_IDLE: begin
          if (req_valid && req_ready) begin
            r_write      <= req_write;
            r_func3      <= req_func3;
            r_addr       <= req_addr;
            r_wdata      <= req_wdata;
            req_ready    <= 1'b0;
            rsp_err      <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_from_mem <= 1'b0;
            if (acc_illegal || acc_misaligned) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else if (acc_in_wb) begin
              state        <= S_WB_WAIT;
              wb_bus_cycle <= 1'b1;
              wb_stb       <= 1'b1;
              wb_we        <= req_write;
              wb_address   <= req_addr[WB_SPAN_LOG2-1:2];
              wb_data_in   <= req_wdata << {req_addr[1:0], 3'b000};
              wb_select    <= acc_select;
            end else begin
              state     <= S_MEM_WAIT;
              mem_write <= req_write;
            end
          end
        end
        S_MEM_WAIT: begin
          state        <= S_RESP;
          rsp_valid    <= 1'b1;
          rsp_from_mem <= 1'b1;
        end
        S_WB_WAIT: begin
          if (wb_error || wb_ack || wb_timeout) begin
            state        <= S_RESP;
            rsp_valid    <= 1'b1;
            wb_bus_cycle <= 1'b0;
            wb_stb       <= 1'b0;
            wb_we        <= 1'b0;
            wb_select    <= '0;
            // Error beats ack; a timeout only fires when neither arrived.
            rsp_err      <= wb_error || !wb_ack;
            rsp_rdata_q  <= (wb_ack && !wb_error) ? wb_load : 32'd0;
          end
        end
        S_RESP: begin
          state        <= S_IDLE;
          req_ready    <= 1'b1;
          rsp_err      <= 1'b0;
          rsp_rdata_q  <= '0;
          rsp_from_mem <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_bridge.sv
// Self-checking bench for mem_wb_bridge: directed test-plan steps followed by
// randomized transactions checked against an arithmetic reference model.
// Honours MEM_WB_BRIDGE_TIMEOUT_EN the same way the design does.
module tb_mem_wb_bridge;
  localparam logic [31:0] WB_BASE      = 32'hFFFFFFE0;
  localparam int          WB_SPAN_LOG2 = 5;
  localparam int          WB_ADDR_W    = 3;
  localparam int          TIMEOUT      = 15;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 req_valid, req_ready, req_write;
  logic [2:0]           req_func3;
  logic [31:0]          req_addr, req_wdata;
  logic                 rsp_valid, rsp_err;
  logic [31:0]          rsp_rdata;
  logic [31:0]          mem_addr, mem_data_in, mem_data_out;
  logic                 mem_write;
  logic [2:0]           mem_control;
  logic [WB_ADDR_W-1:0] wb_address;
  logic [31:0]          wb_data_in, wb_data_out;
  logic                 wb_we, wb_bus_cycle, wb_stb, wb_ack, wb_error;
  logic [3:0]           wb_select;

  int checks = 0;
  int passes = 0;
  int fails  = 0;

  mem_wb_bridge #(
    .WB_BASE(WB_BASE), .WB_SPAN_LOG2(WB_SPAN_LOG2),
    .WB_ADDR_W(WB_ADDR_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_func3(req_func3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_addr(mem_addr), .mem_write(mem_write), .mem_data_in(mem_data_in),
    .mem_control(mem_control), .mem_data_out(mem_data_out),
    .wb_address(wb_address), .wb_data_in(wb_data_in), .wb_data_out(wb_data_out),
    .wb_we(wb_we), .wb_bus_cycle(wb_bus_cycle), .wb_stb(wb_stb),
    .wb_select(wb_select), .wb_ack(wb_ack), .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic int m_bytes(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd4) return 1;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 4;
  endfunction

  function automatic bit m_illegal(input logic [2:0] f);
    return (f == 3'd3) || (f == 3'd6) || (f == 3'd7);
  endfunction

  function automatic bit m_misaligned(input logic [2:0] f, input logic [31:0] a);
    return !m_illegal(f) && ((a % m_bytes(f)) != 0);
  endfunction

  function automatic bit m_in_wb(input logic [31:0] a);
    longint lo = longint'(WB_BASE);
    longint hi = lo + (longint'(1) << WB_SPAN_LOG2) - 1;
    longint v  = longint'(a);
    return (v >= lo) && (v <= hi);
  endfunction

  function automatic logic [3:0] m_select(input logic [2:0] f, input logic [31:0] a);
    int m = ((1 << m_bytes(f)) - 1) << (a % 4);
    return 4'(m);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [31:0] d, input logic [31:0] a);
    longint v = longint'(d) * (longint'(1) << (8 * (a % 4)));
    return 32'(v);
  endfunction

  function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                         input logic [31:0] word);
    longint v   = longint'(word) / (longint'(1) << (8 * (a % 4)));
    longint lim = longint'(1) << (8 * m_bytes(f));
    v = v % lim;
    if ((f == 3'd0 || f == 3'd1) && v >= lim / 2) v = v - lim;
    return 32'(v);
  endfunction

  // One complete transaction. mode: 0 = slave acks, 1 = error, 2 = ack and error together.
  task automatic run_txn(input string nm, input bit wr, input logic [2:0] f,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] slave_word, input int ack_dly, input int mode);
    bit          bad = m_illegal(f) || m_misaligned(f, addr);
    bit          wb  = m_in_wb(addr);
    logic [31:0] mem_word = $urandom;
    @(negedge clk);
    check({nm, "/ready"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = wr; req_func3 = f; req_addr = addr; req_wdata = wdata;
    mem_data_out = mem_word;
    @(negedge clk);
    req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_func3 = 3'($urandom);
    if (bad) begin
      check({nm, "/err_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "/err_flag"}, 32'(rsp_err), 32'd1);
      check({nm, "/err_rdata"}, rsp_rdata, 32'd0);
      check({nm, "/err_no_cyc"}, 32'(wb_bus_cycle), 32'd0);
      check({nm, "/err_no_mw"}, 32'(mem_write), 32'd0);
    end else if (!wb) begin
      check({nm, "/mem_nov"}, 32'(rsp_valid), 32'd0);
      check({nm, "/mem_write"}, 32'(mem_write), 32'(wr));
      check({nm, "/mem_addr"}, mem_addr, addr);
      check({nm, "/mem_ctl"}, 32'(mem_control), 32'(f));
      check({nm, "/mem_din"}, mem_data_in, wdata);
      check({nm, "/mem_no_cyc"}, 32'(wb_bus_cycle), 32'd0);
      @(negedge clk);
      check({nm, "/mem_write_off"}, 32'(mem_write), 32'd0);
      check({nm, "/mem_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "/mem_rsp_err"}, 32'(rsp_err), 32'd0);
      check({nm, "/mem_rdata"}, rsp_rdata, mem_word);
    end else begin
      check({nm, "/wb_cyc"}, 32'(wb_bus_cycle), 32'd1);
      check({nm, "/wb_stb"}, 32'(wb_stb), 32'd1);
      check({nm, "/wb_we"}, 32'(wb_we), 32'(wr));
      check({nm, "/wb_addr"}, 32'(wb_address), (addr - WB_BASE) / 4);
      check({nm, "/wb_sel"}, 32'(wb_select), 32'(m_select(f, addr)));
      check({nm, "/wb_din"}, wb_data_in, m_wdata(wdata, addr));
      check({nm, "/wb_no_mw"}, 32'(mem_write), 32'd0);
      for (int i = 0; i < ack_dly; i++) begin
        @(negedge clk);
        check({nm, "/wb_hold"}, {30'd0, wb_bus_cycle, rsp_valid}, 32'd2);
      end
      wb_data_out = slave_word;
      wb_ack   = (mode != 1);
      wb_error = (mode != 0);
      @(negedge clk);
      wb_ack = 1'b0; wb_error = 1'b0; wb_data_out = $urandom;
      check({nm, "/wb_rsp_valid"}, 32'(rsp_valid), 32'd1);
      check({nm, "/wb_cyc_drop"}, {30'd0, wb_bus_cycle, wb_stb}, 32'd0);
      check({nm, "/wb_rsp_err"}, 32'(rsp_err), 32'(mode != 0));
      check({nm, "/wb_rdata"}, rsp_rdata,
            (mode == 0 && !wr) ? m_load(f, addr, slave_word) : 32'd0);
    end
    @(negedge clk);
    check({nm, "/pulse_end"}, 32'(rsp_valid), 32'd0);
    check({nm, "/ready_back"}, 32'(req_ready), 32'd1);
  endtask

  initial begin
    int high;
    bit rsp_seen;
    reset = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_func3 = '0;
    req_addr = '0; req_wdata = '0; mem_data_out = '0; wb_data_out = '0;
    wb_ack = 1'b0; wb_error = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst/ready", 32'(req_ready), 32'd1);
    check("rst/rsp", {29'd0, rsp_valid, rsp_err, mem_write}, 32'd0);
    check("rst/rdata", rsp_rdata, 32'd0);
    check("rst/wb_ctl", {27'd0, wb_bus_cycle, wb_stb, wb_we, 1'b0, 1'b0}, 32'd0);
    check("rst/wb_sel", 32'(wb_select), 32'd0);
    check("rst/wb_addr", 32'(wb_address), 32'd0);
    check("rst/wb_din", wb_data_in, 32'd0);
    reset = 1'b1;

    // Directed test-plan steps
    run_txn("sw_mem", 1'b1, 3'd2, 32'h0000_0100, 32'hDEAD_BEEF, 32'h0, 0, 0);
    run_txn("lb_wb", 1'b0, 3'd0, 32'hFFFF_FFE5, 32'h0, 32'h0000_8000, 2, 0);
    run_txn("lbu_wb", 1'b0, 3'd4, 32'hFFFF_FFE5, 32'h0, 32'h0000_8000, 2, 0);
    run_txn("sh_wb", 1'b1, 3'd1, 32'hFFFF_FFE2, 32'h0000_1234, 32'h0, 1, 0);
    run_txn("lw_misal", 1'b0, 3'd2, 32'h0000_0102, 32'h0, 32'h0, 0, 0);
    run_txn("f3_illegal", 1'b0, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 0, 0);
    run_txn("lhu_misal", 1'b0, 3'd5, 32'hFFFF_FFE1, 32'h0, 32'h0, 0, 0);
    run_txn("wb_low_edge", 1'b0, 3'd2, 32'hFFFF_FFE0, 32'h0, 32'hCAFE_F00D, 0, 0);
    run_txn("wb_high_edge", 1'b0, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'h7F00_0000, 1, 0);
    run_txn("mem_below_win", 1'b0, 3'd0, 32'hFFFF_FFDF, 32'h0, 32'h0, 0, 0);
    run_txn("lh_wb_sign", 1'b0, 3'd1, 32'hFFFF_FFEE, 32'h0, 32'h8001_0000, 3, 0);
    run_txn("wb_error", 1'b0, 3'd2, 32'hFFFF_FFF0, 32'h0, 32'h1234_5678, 1, 1);
    run_txn("wb_ack_and_err", 1'b0, 3'd2, 32'hFFFF_FFF4, 32'h0, 32'h1234_5678, 0, 2);

    // Reset while a Wishbone cycle is open
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'd2; req_addr = 32'hFFFF_FFE4;
    @(negedge clk);
    req_valid = 1'b0;
    check("midrst/cyc_open", 32'(wb_bus_cycle), 32'd1);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    check("midrst/cyc", {30'd0, wb_bus_cycle, wb_stb}, 32'd0);
    check("midrst/sel", 32'(wb_select), 32'd0);
    check("midrst/rsp", {30'd0, rsp_valid, rsp_err}, 32'd0);
    check("midrst/ready", 32'(req_ready), 32'd1);
    reset = 1'b1;
    rsp_seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
    end
    check("midrst/no_rsp", 32'(rsp_seen), 32'd0);
    check("midrst/ready_after", 32'(req_ready), 32'd1);

    // Unanswered Wishbone read
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_func3 = 3'd2; req_addr = 32'hFFFF_FFE8;
    @(negedge clk);
    req_valid = 1'b0;
`ifdef MEM_WB_BRIDGE_TIMEOUT_EN
    high = 0;
    for (int i = 0; i < 200 && wb_bus_cycle; i++) begin
      high++;
      @(negedge clk);
    end
    check("timeout/cyc_cycles", 32'(high), 32'(TIMEOUT));
    check("timeout/rsp_valid", 32'(rsp_valid), 32'd1);
    check("timeout/rsp_err", 32'(rsp_err), 32'd1);
    check("timeout/rdata", rsp_rdata, 32'd0);
    @(negedge clk);
    check("timeout/ready", 32'(req_ready), 32'd1);
`else
    high = 0;
    rsp_seen = 1'b0;
    repeat (100) begin
      @(negedge clk);
      if (rsp_valid) rsp_seen = 1'b1;
      if (wb_bus_cycle) high++;
    end
    check("hold/cyc_cycles", 32'(high), 32'd100);
    check("hold/no_rsp", 32'(rsp_seen), 32'd0);
    wb_data_out = 32'h1122_3344; wb_ack = 1'b1;
    @(negedge clk);
    wb_ack = 1'b0;
    check("hold/rsp_valid", 32'(rsp_valid), 32'd1);
    check("hold/rsp_err", 32'(rsp_err), 32'd0);
    check("hold/rdata", rsp_rdata, 32'h1122_3344);
    @(negedge clk);
    check("hold/ready", 32'(req_ready), 32'd1);
`endif

    // Randomized traffic against the model
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int          md;
      int          pick;
      pick = int'($urandom_range(0, 9));
      md   = (pick == 0) ? 1 : ((pick == 1) ? 2 : 0);
      if ($urandom_range(0, 1) == 1) a = WB_BASE + 32'($urandom_range(0, 31));
      else                          a = $urandom;
      run_txn("rand", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), a,
              $urandom, $urandom, int'($urandom_range(0, 4)), md);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
